// File: rtl/cnn_error_accumulator.sv
// cnn_error_accumulator: scores each CNN output word against a cyclic table of expected values and
// accumulates saturating SSE / SAE / sample count per frame. `CNN_ERR_MAX_TRACK_EN adds peak-error tracking.
module cnn_error_accumulator #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 15,
    parameter int NUM_REF = 30,
    parameter int ACC_W   = 48,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ref_we,
    input  logic [$clog2(NUM_REF)-1:0] ref_waddr,
    input  logic signed [DATA_W-1:0]   ref_wdata,
    input  logic                       start,
    input  logic signed [DATA_W-1:0]   out_data,
    input  logic [ADDR_W-1:0]          out_addr,
    input  logic                       out_valid,
    input  logic                       cnn_done,
    output logic [ACC_W-1:0]           sse,
    output logic [ACC_W-1:0]           sae,
    output logic [CNT_W-1:0]           count,
    output logic                       busy,
    output logic                       result_valid,
    output logic                       overflow
`ifdef CNN_ERR_MAX_TRACK_EN
    ,
    output logic [DATA_W:0]            max_abs_err,
    output logic [ADDR_W-1:0]          max_err_addr
`endif
);
    localparam int IDX_W = $clog2(NUM_REF);
    localparam int SQ_W  = 2 * DATA_W + 2;
    localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REF - 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, DONE} state_t;

    state_t state, state_nxt;
    logic   clear, accept;

    // Add inc into acc; bit ACC_W flags that the result was clamped to all-ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc, input logic [SQ_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(acc) + SUM_W'(inc);
        if (sum > SUM_W'({ACC_W{1'b1}}))
            sat_add = {1'b1, {ACC_W{1'b1}}};
        else
            sat_add = {1'b0, sum[ACC_W-1:0]};
    endfunction

    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt)
            sat_inc = {1'b1, cnt};
        else
            sat_inc = {1'b0, cnt + CNT_W'(1)};
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    clear     = 1'b1;
                end
            end
            RUN: begin
                accept = out_valid;
                if (cnn_done)
                    state_nxt = DRAIN1;
            end
            DRAIN1:  state_nxt = DRAIN2;
            DRAIN2:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy         = (state == RUN) || (state == DRAIN1) || (state == DRAIN2);
    assign result_valid = (state == DONE);

    logic signed [DATA_W-1:0] ref_mem [NUM_REF];
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] ref_rd;

    // Reads are combinational ahead of the write edge, so a same-index write lands after S1 used the old value.
    always_ff @(posedge clk) begin
        if (ref_we && (ref_waddr <= LAST_IDX))
            ref_mem[ref_waddr] <= ref_wdata;
    end

    assign ref_rd = ref_mem[idx];

    always_ff @(posedge clk) begin
        if (reset || clear)
            idx <= '0;
        else if (accept)
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end

    // ---- stage 0 -> 1: difference against the expected word ----
    logic signed [DATA_W:0] diff_p0;
    logic [DATA_W:0]        abs_p0;
    logic signed [DATA_W:0] diff_p1;
    logic [DATA_W:0]        abs_p1;
    logic                   vld_p1;

    assign diff_p0 = {out_data[DATA_W-1], out_data} - {ref_rd[DATA_W-1], ref_rd};
    assign abs_p0  = diff_p0[DATA_W] ? $unsigned(-diff_p0) : $unsigned(diff_p0);

    always_ff @(posedge clk) begin
        if (accept) begin
            diff_p1 <= diff_p0;
            abs_p1  <= abs_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= accept;
    end

    // ---- stage 1 -> 2: square and accumulate with saturation ----
    logic signed [SQ_W-1:0] diff_ext_p1;
    logic signed [SQ_W-1:0] sq_p1;
    logic [ACC_W:0]         sse_nxt;
    logic [ACC_W:0]         sae_nxt;
    logic [CNT_W:0]         cnt_nxt;

    assign diff_ext_p1 = {{(SQ_W-DATA_W-1){diff_p1[DATA_W]}}, diff_p1};
    assign sq_p1       = diff_ext_p1 * diff_ext_p1;
    assign sse_nxt     = sat_add(sse, $unsigned(sq_p1));
    assign sae_nxt     = sat_add(sae, SQ_W'(abs_p1));
    assign cnt_nxt     = sat_inc(count);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sse      <= '0;
            sae      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (vld_p1) begin
            sse      <= sse_nxt[ACC_W-1:0];
            sae      <= sae_nxt[ACC_W-1:0];
            count    <= cnt_nxt[CNT_W-1:0];
            overflow <= overflow | sse_nxt[ACC_W] | sae_nxt[ACC_W] | cnt_nxt[CNT_W];
        end
    end

`ifdef CNN_ERR_MAX_TRACK_EN
    logic [ADDR_W-1:0] addr_p1;

    always_ff @(posedge clk) begin
        if (accept)
            addr_p1 <= out_addr;
    end

    // Strictly-greater compare keeps the first address on ties.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            max_abs_err  <= '0;
            max_err_addr <= '0;
        end else if (vld_p1 && (abs_p1 > max_abs_err)) begin
            max_abs_err  <= abs_p1;
            max_err_addr <= addr_p1;
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^out_addr;
`endif

endmodule

// File: tb/tb_cnn_error_accumulator.sv
// Scoreboard bench for cnn_error_accumulator (ACC_W=32 so accumulator saturation is reachable).
module tb_cnn_error_accumulator;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 15;
    localparam int NUM_REF = 30;
    localparam int ACC_W   = 32;
    localparam int CNT_W   = 32;
    localparam int IDX_W   = $clog2(NUM_REF);
    localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     ref_we = 1'b0;
    logic [IDX_W-1:0]         ref_waddr = '0;
    logic signed [DATA_W-1:0] ref_wdata = '0;
    logic                     start = 1'b0;
    logic signed [DATA_W-1:0] out_data = '0;
    logic [ADDR_W-1:0]        out_addr = '0;
    logic                     out_valid = 1'b0;
    logic                     cnn_done = 1'b0;
    logic [ACC_W-1:0]         sse;
    logic [ACC_W-1:0]         sae;
    logic [CNT_W-1:0]         count;
    logic                     busy;
    logic                     result_valid;
    logic                     overflow;
`ifdef CNN_ERR_MAX_TRACK_EN
    logic [DATA_W:0]          max_abs_err;
    logic [ADDR_W-1:0]        max_err_addr;
`endif

    always #5 clk = ~clk;

    cnn_error_accumulator #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REF(NUM_REF), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ref_we(ref_we), .ref_waddr(ref_waddr), .ref_wdata(ref_wdata),
        .start(start), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .cnn_done(cnn_done),
        .sse(sse), .sae(sae), .count(count),
        .busy(busy), .result_valid(result_valid), .overflow(overflow)
`ifdef CNN_ERR_MAX_TRACK_EN
        , .max_abs_err(max_abs_err), .max_err_addr(max_err_addr)
`endif
    );

    typedef struct {
        longint sse;
        longint sae;
        longint cnt;
        bit     ovf;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic signed [DATA_W-1:0] ref_m [NUM_REF];
    logic [DATA_W-1:0]        frame_q[$];
    logic [ADDR_W-1:0]        addr_q[$];
    exp_t                     exp_q[$];
    exp_t                     mon_e;
    logic                     rv_q = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic wr_ref(input int i, input logic [DATA_W-1:0] v);
        ref_we    = 1'b1;
        ref_waddr = IDX_W'(i);
        ref_wdata = v;
        @(negedge clk);
        ref_we    = 1'b0;
        ref_m[i]  = v;
    endtask

    task automatic fill_ref(input logic [DATA_W-1:0] v);
        for (int i = 0; i < NUM_REF; i++) wr_ref(i, v);
    endtask

    task automatic add_sample(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a);
        frame_q.push_back(d);
        addr_q.push_back(a);
    endtask

    // Drives start plus the queued frame (cnn_done on the last word) and pushes the modelled metrics.
    // With noise set, start is also pulsed mid-frame and one extra valid word follows cnn_done.
    task automatic send_frame(input bit noise);
        exp_t   e;
        int     idx;
        int     n;
        longint d;
        longint a;
        e.sse = 0; e.sae = 0; e.cnt = 0; e.ovf = 1'b0;
        idx = 0;
        n = frame_q.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            out_valid = 1'b1;
            out_data  = frame_q[k];
            out_addr  = addr_q[k];
            cnn_done  = (k == n - 1);
            start     = noise && (k == n / 2);
            d = longint'($signed(frame_q[k])) - longint'(ref_m[idx]);
            a = (d < 0) ? -d : d;
            e.sse += d * d;
            if (e.sse > ACC_MAX) begin e.sse = ACC_MAX; e.ovf = 1'b1; end
            e.sae += a;
            if (e.sae > ACC_MAX) begin e.sae = ACC_MAX; e.ovf = 1'b1; end
            e.cnt++;
            idx = (idx + 1) % NUM_REF;
            @(negedge clk);
        end
        start    = 1'b0;
        cnn_done = 1'b0;
        if (noise) begin
            out_data = 16'sh1234;
            @(negedge clk);
        end
        out_valid = 1'b0;
        exp_q.push_back(e);
        frame_q.delete();
        addr_q.delete();
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(result_valid), 64'd1);
    endtask

    // Scoreboard: pop the expected metrics when the DUT declares a frame complete.
    always @(negedge clk) begin
        if (result_valid && !rv_q) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sse", 64'(sse), mon_e.sse);
                chk("sae", 64'(sae), mon_e.sae);
                chk("count", 64'(count), mon_e.cnt);
                chk("overflow", 64'(overflow), 64'(mon_e.ovf));
                chk("busy_at_done", 64'(busy), 64'd0);
            end
        end
        rv_q <= result_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sse", 64'(sse), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Frame 1: +1, -1, 0 errors, then exact drain timing.
        fill_ref(16'h00FF);
        add_sample(16'h0100, 15'd0);
        add_sample(16'h00FE, 15'd1);
        add_sample(16'h00FF, 15'd2);
        send_frame(1'b0);
        chk("t1_busy_n0", 64'(busy), 64'd1);
        chk("t1_rv_n0", 64'(result_valid), 64'd0);
        @(negedge clk);
        chk("t1_rv_n1", 64'(result_valid), 64'd0);
        chk("t1_busy_n1", 64'(busy), 64'd1);
        chk("t1_sse_n1", 64'(sse), 64'd2);
        @(negedge clk);
        chk("t1_rv_n2", 64'(result_valid), 64'd1);
        chk("t1_busy_n2", 64'(busy), 64'd0);

        // Frame 2: 31 samples wrap the table index; start mid-frame and a trailing valid are ignored.
        wr_ref(0, 16'd10);
        for (int i = 1; i < NUM_REF; i++) wr_ref(i, 16'd0);
        for (int i = 0; i < 31; i++) add_sample(16'd10, ADDR_W'(i));
        send_frame(1'b1);
        wait_result("t2_done");
        chk("t2_sse_const", 64'(sse), 64'd2900);
        chk("t2_sae_const", 64'(sae), 64'd290);

        // Frame 3: most negative minus most positive, plus 2-edge latency.
        wr_ref(0, 16'h7FFF);
        add_sample(16'h8000, 15'd0);
        send_frame(1'b0);
        chk("t3_sse_lat1", 64'(sse), 64'd0);
        chk("t3_cnt_lat1", 64'(count), 64'd0);
        @(negedge clk);
        chk("t3_sse_lat2", 64'(sse), 64'd4294836225);
        chk("t3_cnt_lat2", 64'(count), 64'd1);
        wait_result("t3_done");

        // Frame 4: second large error saturates the 32-bit SSE.
        wr_ref(1, 16'h7FFF);
        add_sample(16'h8000, 15'd0);
        add_sample(16'h8000, 15'd1);
        send_frame(1'b0);
        wait_result("t4_done");
        chk("t4_sse_clamp", 64'(sse), 64'hFFFF_FFFF);
        chk("t4_ovf", 64'(overflow), 64'd1);

        // Reset in the middle of a running frame, with out_valid held high.
        fill_ref(16'h00FF);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        out_valid = 1'b1;
        out_data  = 16'h0180;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_sse", 64'(sse), 64'd0);
        chk("t5_sae", 64'(sae), 64'd0);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_rv", 64'(result_valid), 64'd0);
        chk("t5_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_idle_count", 64'(count), 64'd0);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        out_valid = 1'b0;
        add_sample(16'h0100, 15'd0);
        add_sample(16'h00FE, 15'd1);
        add_sample(16'h00FF, 15'd2);
        send_frame(1'b0);
        wait_result("t5_done");
        chk("t5_sse_final", 64'(sse), 64'd2);

`ifdef CNN_ERR_MAX_TRACK_EN
        for (int i = 0; i < 3; i++) wr_ref(i, 16'd0);
        add_sample(16'd3, 15'd5);
        add_sample(16'd7, 15'd9);
        add_sample(16'hFFF9, 15'd12);
        send_frame(1'b0);
        wait_result("t6_done");
        chk("t6_max_err", 64'(max_abs_err), 64'd7);
        chk("t6_max_addr", 64'(max_err_addr), 64'd9);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
